// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and request-validity helpers for the load/store master.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Size is funct3[1:0]: 00 byte (never misaligned), 01 half, 10 word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addrLow);
    case (size)
      2'b01:   return addrLow[0];
      2'b10:   return addrLow != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Loads reject 011/110/111; stores only know sb/sh/sw.
  function automatic logic is_illegal(input logic isStore, input logic [2:0] funct3);
    if (isStore) begin
      return funct3[2] | (funct3[1:0] == 2'b11);
    end
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: extracts/extends load data and merges sub-word store data into a word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata,
  output logic [31:0] wd
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then sign/zero-extend by access type.
  always_comb begin
    shifted = word >> {offset, 3'b000};
    rdata   = shifted;
    case (funct3)
      F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata = {24'b0, shifted[7:0]};
      F3_HU:   rdata = {16'b0, shifted[15:0]};
      default: rdata = shifted;
    endcase
  end

  // Overwrite only the targeted byte or half of the word read back; other lanes keep their data.
  always_comb begin
    wd = word;
    case (funct3)
      F3_B: begin
        for (int i = 0; i < 4; i++) begin
          if (offset == 2'(i)) wd[8*i +: 8] = wdata[7:0];
        end
      end
      F3_H: begin
        if (offset[1]) wd[31:16] = wdata;
        else           wd[15:0]  = wdata;
      end
      default: wd = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one request at a time, RMW for sub-word stores, registered response.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);

  state_t      state_q;
  logic        reqWe_q;
  logic [2:0]  reqFunct3_q;
  logic [31:0] reqAddr_q;
  logic [15:0] reqWdata_q;
  logic [31:0] wordWd_q;
  logic        reqReady_q;
  logic        respValid_q;
  logic [31:0] respRdata_q;
  logic        respErr_q;

  logic [31:0] loadData;
  logic [31:0] mergedWord;
  logic        reqBad;

  lsu_align u_align (
    .word   (mem_rd),
    .wdata  (reqWdata_q),
    .offset (reqAddr_q[1:0]),
    .funct3 (reqFunct3_q),
    .rdata  (loadData),
    .wd     (mergedWord)
  );

  assign reqBad = is_illegal(req_we, req_funct3) | is_misaligned(req_funct3[1:0], req_addr[1:0]);

  // Memory port is a pure decode of the registered state so reset removes mem_we at once.
  assign mem_we   = (state_q == WR);
  assign mem_addr = (state_q == RD || state_q == WR) ? {reqAddr_q[31:2], 2'b00} : 32'd0;
  assign mem_wd   = (state_q == WR) ? wordWd_q : 32'd0;

  assign req_ready  = reqReady_q;
  assign resp_valid = respValid_q;
  assign resp_rdata = respRdata_q;
  assign resp_err   = respErr_q;

  // Request sequencer: latch on accept, walk RD/WR as needed, pulse the response, return to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      reqWe_q     <= 1'b0;
      reqFunct3_q <= 3'b000;
      reqAddr_q   <= 32'd0;
      reqWdata_q  <= 16'd0;
      wordWd_q    <= 32'd0;
      reqReady_q  <= 1'b1;
      respValid_q <= 1'b0;
      respRdata_q <= 32'd0;
      respErr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            reqWe_q     <= req_we;
            reqFunct3_q <= req_funct3;
            reqAddr_q   <= req_addr;
            reqWdata_q  <= req_wdata[15:0];
            wordWd_q    <= req_wdata;
            reqReady_q  <= 1'b0;
            if (reqBad) begin
              state_q     <= RESP;
              respValid_q <= 1'b1;
              respErr_q   <= 1'b1;
              respRdata_q <= 32'd0;
            end else if (req_we && req_funct3 == F3_W) begin
              state_q <= WR;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD: begin
          if (reqWe_q) begin
            wordWd_q <= mergedWord;
            state_q  <= WR;
          end else begin
            respRdata_q <= loadData;
            respValid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        WR: begin
          respRdata_q <= 32'd0;
          respValid_q <= 1'b1;
          state_q     <= RESP;
        end
        default: begin
          respValid_q <= 1'b0;
          respRdata_q <= 32'd0;
          respErr_q   <= 1'b0;
          reqReady_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule
